// File: rtl/baccarat_pkg.sv
// Shared types, Baccarat rule constants and small score/card helpers for the round controller.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_EVAL,
    S_P3,
    S_BDEC,
    S_D3,
    S_DONE
  } state_t;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] BANKER_STAND    = 4'd7;

  // Face cards, tens and "no card" all count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd1 && rank <= 4'd9) ? rank : 4'd0;
  endfunction

  // Out-of-range scores are treated as 9.
  function automatic logic [3:0] clamp_score(input logic [3:0] score);
    return (score > 4'd9) ? 4'd9 : score;
  endfunction

endpackage

// File: rtl/baccarat_round_ctrl_if.sv
// Controller <-> datapath/board bundle: scores and third-card rank in, load strobes and lights out.
interface baccarat_round_ctrl_if;

  logic [3:0] pscore_out;
  logic [3:0] dscore_out;
  logic [3:0] pcard3_out;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       round_done;

  modport master (
    input  pscore_out, dscore_out, pcard3_out,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, round_done
  );

  modport slave (
    output pscore_out, dscore_out, pcard3_out,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, round_done
  );

endinterface

// File: rtl/banker_draw_rule.sv
// Banker third-card decision: plain "draw on 0-5" when the player stood, tableau otherwise.
module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  input  logic       player_drew,
  output logic       draw
);

  logic [3:0] d;
  assign d = clamp_score(dscore);

  always_comb begin
    draw = 1'b0;
    if (!player_drew) begin
      draw = (d <= PLAYER_DRAW_MAX);
    end else if (d < BANKER_STAND) begin
      case (d)
        4'd0, 4'd1, 4'd2: draw = 1'b1;
        4'd3:             draw = (pcard3 != 4'd8);
        4'd4:             draw = (pcard3 >= 4'd2 && pcard3 <= 4'd7);
        4'd5:             draw = (pcard3 >= 4'd4 && pcard3 <= 4'd7);
        4'd6:             draw = (pcard3 >= 4'd6 && pcard3 <= 4'd7);
        default:          draw = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// One-round Baccarat sequencer: deals P1/D1/P2/D2, applies natural and tableau rules, holds the result.
module baccarat_round_ctrl
  import baccarat_pkg::*;
(
  input  logic                   slow_clock,
  input  logic                   reset,
  baccarat_round_ctrl_if.master  bus
);

  state_t     state, state_next;
  logic [3:0] p, d, pcard3_value;
  logic       in_bdec, banker_draw;

  assign p            = clamp_score(bus.pscore_out);
  assign d            = clamp_score(bus.dscore_out);
  assign pcard3_value = card_value(bus.pcard3_out);
  assign in_bdec      = (state == S_BDEC);

  banker_draw_rule u_banker_draw_rule (
    .dscore      (bus.dscore_out),
    .pcard3      (pcard3_value),
    .player_drew (in_bdec),
    .draw        (banker_draw)
  );

  always_ff @(posedge slow_clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next           = S_IDLE;
    bus.load_pcard1      = 1'b0;
    bus.load_pcard2      = 1'b0;
    bus.load_pcard3      = 1'b0;
    bus.load_dcard1      = 1'b0;
    bus.load_dcard2      = 1'b0;
    bus.load_dcard3      = 1'b0;
    bus.player_win_light = 1'b0;
    bus.dealer_win_light = 1'b0;
    bus.round_done       = 1'b0;
    case (state)
      S_IDLE: state_next = S_P1;
      S_P1: begin bus.load_pcard1 = 1'b1; state_next = S_D1; end
      S_D1: begin bus.load_dcard1 = 1'b1; state_next = S_P2; end
      S_P2: begin bus.load_pcard2 = 1'b1; state_next = S_D2; end
      S_D2: begin bus.load_dcard2 = 1'b1; state_next = S_EVAL; end
      // Shared rule instance sees player_drew=0 here, so it reduces to "banker draws on 0-5".
      S_EVAL: begin
        if (p >= NATURAL_MIN || d >= NATURAL_MIN) state_next = S_DONE;
        else if (p <= PLAYER_DRAW_MAX)            state_next = S_P3;
        else if (banker_draw)                     state_next = S_D3;
        else                                      state_next = S_DONE;
      end
      S_P3: begin bus.load_pcard3 = 1'b1; state_next = S_BDEC; end
      S_BDEC: state_next = banker_draw ? S_D3 : S_DONE;
      S_D3: begin bus.load_dcard3 = 1'b1; state_next = S_DONE; end
      S_DONE: begin
        state_next           = S_DONE;
        bus.round_done       = 1'b1;
        bus.player_win_light = (p >= d);
        bus.dealer_win_light = (d >= p);
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for baccarat_round_ctrl: per-scenario tasks compared against a rule-table model of a round.
module tb_baccarat_round_ctrl;

  logic slow_clock = 1'b0;
  logic reset      = 1'b1;
  always #5 slow_clock = ~slow_clock;

  baccarat_round_ctrl_if bus ();

  baccarat_round_ctrl dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus)
  );

  logic [3:0] rule_dscore, rule_pcard3;
  logic       rule_player_drew, rule_draw;

  banker_draw_rule u_rule (
    .dscore      (rule_dscore),
    .pcard3      (rule_pcard3),
    .player_drew (rule_player_drew),
    .draw        (rule_draw)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] L_P1   = 6'b100000;
  localparam logic [5:0] L_D1   = 6'b010000;
  localparam logic [5:0] L_P2   = 6'b001000;
  localparam logic [5:0] L_D2   = 6'b000100;
  localparam logic [5:0] L_P3   = 6'b000010;
  localparam logic [5:0] L_D3   = 6'b000001;
  localparam logic [5:0] L_NONE = 6'b000000;

  // Banker tableau after the player drew: bit v set = banker draws on player third-card value v.
  localparam logic [9:0] DRAW_MASK [10] = '{
    10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC,
    10'h0F0, 10'h0C0, 10'h000, 10'h000, 10'h000
  };

  logic [5:0] exp_trace [$];
  logic [8:0] obs_trace [$];

  function automatic int sat9(input int s);
    return (s > 9) ? 9 : s;
  endfunction

  function automatic int value_of(input int rank);
    return (rank >= 1 && rank <= 9) ? rank : 0;
  endfunction

  function automatic logic [5:0] strobes();
    return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
            bus.load_dcard2, bus.load_pcard3, bus.load_dcard3};
  endfunction

  function automatic logic [8:0] observe();
    return {strobes(), bus.round_done, bus.player_win_light, bus.dealer_win_light};
  endfunction

  // Expected strobe per cycle (cycle 1 = first edge after reset release) for constant scores.
  task automatic model_round(input int p, input int d, input int rank);
    int  p9, d9;
    bit  natural, pdraw, bdraw;
    p9 = sat9(p);
    d9 = sat9(d);
    natural = (p9 >= 8) || (d9 >= 8);
    pdraw   = !natural && (p9 <= 5);
    if (natural)     bdraw = 1'b0;
    else if (!pdraw) bdraw = (d9 <= 5);
    else             bdraw = DRAW_MASK[d9][value_of(rank)];
    exp_trace = '{L_P1, L_D1, L_P2, L_D2, L_NONE};
    if (pdraw) begin
      exp_trace.push_back(L_P3);
      exp_trace.push_back(L_NONE);
    end
    if (bdraw) exp_trace.push_back(L_D3);
  endtask

  function automatic logic [8:0] expected_at(input int k, input int p, input int d);
    logic pw, dw;
    pw = (sat9(p) >= sat9(d));
    dw = (sat9(d) >= sat9(p));
    if (k == 0) return 9'd0;
    if (k <= exp_trace.size()) return {exp_trace[k-1], 3'b000};
    return {L_NONE, 1'b1, pw, dw};
  endfunction

  // Resets, releases, and records outputs for cycles 0..ncyc (0 = still idle after reset).
  task automatic play_round(input int p, input int d, input int rank, input int ncyc);
    bus.pscore_out = 4'(p);
    bus.dscore_out = 4'(d);
    bus.pcard3_out = 4'(rank);
    reset = 1'b1;
    @(negedge slow_clock);
    @(negedge slow_clock);
    reset = 1'b0;
    obs_trace.delete();
    obs_trace.push_back(observe());
    repeat (ncyc) begin
      @(negedge slow_clock);
      obs_trace.push_back(observe());
    end
  endtask

  // Strobe invariants on every sampled cycle.
  always @(negedge slow_clock) begin
    if (!reset) begin
      checks++;
      if (!$onehot0(strobes()) || (bus.round_done && strobes() != L_NONE)) begin
        errors++;
        $display("FAIL strobe_invariant t=%0t: strobes=%b done=%b, required onehot0 and none when done",
                 $time, strobes(), bus.round_done);
      end
    end
  end

  task automatic test_reset();
    bus.pscore_out = 4'($urandom_range(0, 15));
    bus.dscore_out = 4'($urandom_range(0, 15));
    bus.pcard3_out = 4'($urandom_range(0, 15));
    reset = 1'b1;
    @(negedge slow_clock);
    @(negedge slow_clock);
    checks++;
    if (observe() !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: got %b, expected %b", observe(), 9'd0);
    end
  endtask

  task automatic test_deal_sequence();
    model_round(3, 2, 4);
    play_round(3, 2, 4, 12);
    for (int k = 0; k <= 12; k++) begin
      checks++;
      if (obs_trace[k] !== expected_at(k, 3, 2)) begin
        errors++;
        $display("FAIL deal_seq cycle %0d: got %b, expected %b", k, obs_trace[k], expected_at(k, 3, 2));
      end
    end
    checks++;
    if (obs_trace[6][8:3] !== L_P3 || obs_trace[8][8:3] !== L_D3) begin
      errors++;
      $display("FAIL deal_third_cards: c6=%b c8=%b, expected %b and %b",
               obs_trace[6][8:3], obs_trace[8][8:3], L_P3, L_D3);
    end
    checks++;
    if (obs_trace[8][2] !== 1'b0 || obs_trace[9][2:0] !== 3'b110) begin
      errors++;
      $display("FAIL deal_done_latency: c8 done=%b c9=%b, expected 0 and 110", obs_trace[8][2], obs_trace[9][2:0]);
    end
  endtask

  task automatic test_natural();
    int r;
    r = int'($urandom_range(0, 13));
    model_round(8, 5, r);
    play_round(8, 5, r, 10);
    for (int k = 0; k <= 10; k++) begin
      checks++;
      if (obs_trace[k] !== expected_at(k, 8, 5)) begin
        errors++;
        $display("FAIL natural cycle %0d: got %b, expected %b", k, obs_trace[k], expected_at(k, 8, 5));
      end
    end
    checks++;
    if (obs_trace[5][2] !== 1'b0 || obs_trace[6] !== {L_NONE, 3'b110}) begin
      errors++;
      $display("FAIL natural_done: c5 done=%b c6=%b, expected 0 and %b", obs_trace[5][2], obs_trace[6], {L_NONE, 3'b110});
    end
  endtask

  task automatic test_stand_banker_draw();
    int r;
    r = int'($urandom_range(0, 13));
    model_round(6, 4, r);
    play_round(6, 4, r, 10);
    for (int k = 0; k <= 10; k++) begin
      checks++;
      if (obs_trace[k] !== expected_at(k, 6, 4)) begin
        errors++;
        $display("FAIL stand_draw cycle %0d: got %b, expected %b", k, obs_trace[k], expected_at(k, 6, 4));
      end
    end
    checks++;
    if (obs_trace[6][8:3] !== L_D3 || obs_trace[7][2] !== 1'b1) begin
      errors++;
      $display("FAIL stand_draw_d3: c6=%b c7 done=%b, expected %b and 1", obs_trace[6][8:3], obs_trace[7][2], L_D3);
    end
    bus.dscore_out = 4'd6;
    #1;
    checks++;
    if ({bus.round_done, bus.player_win_light, bus.dealer_win_light} !== 3'b111) begin
      errors++;
      $display("FAIL tie_lights: got %b, expected 111",
               {bus.round_done, bus.player_win_light, bus.dealer_win_light});
    end
  endtask

  task automatic test_banker_table();
    for (int d = 0; d <= 7; d++) begin
      for (int rank = 0; rank <= 13; rank++) begin
        rule_dscore      = 4'(d);
        rule_pcard3      = 4'(value_of(rank));
        rule_player_drew = 1'b1;
        #1;
        checks++;
        if (rule_draw !== DRAW_MASK[d][value_of(rank)]) begin
          errors++;
          $display("FAIL rule_tableau d=%0d rank=%0d: got %b, expected %b",
                   d, rank, rule_draw, DRAW_MASK[d][value_of(rank)]);
        end
        rule_player_drew = 1'b0;
        #1;
        checks++;
        if (rule_draw !== (d <= 5)) begin
          errors++;
          $display("FAIL rule_stood d=%0d: got %b, expected %b", d, rule_draw, (d <= 5));
        end
        if (rank >= 1) begin
          model_round(3, d, rank);
          play_round(3, d, rank, 10);
          for (int k = 0; k <= 10; k++) begin
            checks++;
            if (obs_trace[k] !== expected_at(k, 3, d)) begin
              errors++;
              $display("FAIL table_fsm d=%0d rank=%0d cycle %0d: got %b, expected %b",
                       d, rank, k, obs_trace[k], expected_at(k, 3, d));
            end
          end
        end
      end
    end
  endtask

  task automatic test_random_rounds();
    int p, d, r;
    for (int n = 0; n < 80; n++) begin
      p = int'($urandom_range(0, 15));
      d = int'($urandom_range(0, 15));
      r = int'($urandom_range(0, 15));
      model_round(p, d, r);
      play_round(p, d, r, 11);
      for (int k = 0; k <= 11; k++) begin
        checks++;
        if (obs_trace[k] !== expected_at(k, p, d)) begin
          errors++;
          $display("FAIL random p=%0d d=%0d r=%0d cycle %0d: got %b, expected %b",
                   p, d, r, k, obs_trace[k], expected_at(k, p, d));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    play_round(3, 2, 4, 6);
    checks++;
    if (obs_trace[6] !== {L_P3, 3'b000}) begin
      errors++;
      $display("FAIL midreset_in_p3: got %b, expected %b", obs_trace[6], {L_P3, 3'b000});
    end
    reset = 1'b1;
    @(negedge slow_clock);
    checks++;
    if (observe() !== 9'd0) begin
      errors++;
      $display("FAIL midreset_cleared: got %b, expected %b", observe(), 9'd0);
    end
    reset = 1'b0;
    @(negedge slow_clock);
    checks++;
    if (observe() !== {L_P1, 3'b000}) begin
      errors++;
      $display("FAIL midreset_restart: got %b, expected %b", observe(), {L_P1, 3'b000});
    end
  endtask

  initial begin
    rule_dscore      = 4'd0;
    rule_pcard3      = 4'd0;
    rule_player_drew = 1'b0;
    test_reset();
    test_deal_sequence();
    test_natural();
    test_stand_banker_draw();
    test_banker_table();
    test_random_rounds();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
